// File: rtl/fpu_pkg.sv
// fpu_pkg: shared encodings and queue entry layout for the FPU sign-injection operand path.
//   funct3 encodings, one-hot op codes, canonical SP NaN, entry data width and funct3 decoder.
package fpu_pkg;
    localparam logic [2:0] F3_SGNJ  = 3'b000;
    localparam logic [2:0] F3_SGNJN = 3'b001;
    localparam logic [2:0] F3_SGNJX = 3'b010;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_SGNJ  = 3'b001,
        OP_SGNJN = 3'b010,
        OP_SGNJX = 3'b100
    } op_e;

    localparam logic [31:0] CANON_NAN_SP = 32'h7FC0_0000;

    // Entry layout, MSB to LSB: rs1[63:0], rs2[63:0], sp_dp, operation[2:0], illegal, then the tag.
    localparam int ENTRY_DATA_W = 64 + 64 + 1 + 3 + 1;

    function automatic op_e decode_funct3(input logic [2:0] f3);
        return f3 == F3_SGNJ  ? OP_SGNJ  :
               f3 == F3_SGNJN ? OP_SGNJN :
               f3 == F3_SGNJX ? OP_SGNJX : OP_NONE;
    endfunction
endpackage

// File: rtl/fpu_nan_unbox.sv
// fpu_nan_unbox: combinational NaN-unboxing of one 64-bit FP register operand.
//   value  in 64 : raw register value
//   fmt    in 1  : 1 = DP (pass through), 0 = SP
//   result out 64: DP value, or zero-extended SP value / canonical NaN when improperly boxed
module fpu_nan_unbox #(
    parameter logic [31:0] CANON_NAN_SP = fpu_pkg::CANON_NAN_SP
) (
    input  logic [63:0] value,
    input  logic        fmt,
    output logic [63:0] result
);
    assign result = fmt             ? value :
                    &value[63:32]   ? {32'h0, value[31:0]} :
                                      {32'h0, CANON_NAN_SP};
endmodule

// File: rtl/fpu_sgnj_operand_stage.sv
// fpu_sgnj_operand_stage: unboxes and decodes sign-injection ops into a 2-entry FIFO feeding the FSGNJ unit.
//   CLK/RST_N/FLUSH          : clock, async active-low reset, sync queue clear
//   IN_VALID/IN_READY        : upstream handshake; IN_RS1/IN_RS2/IN_FMT/IN_FUNCT3/IN_TAG payload
//   OUT_VALID/OUT_READY      : downstream handshake
//   INPUT_1/INPUT_2/SP_DP/OPERATION/OUT_TAG/ILLEGAL : head entry, all zero when empty
module fpu_sgnj_operand_stage #(
    parameter logic [31:0] CANON_NAN_SP = fpu_pkg::CANON_NAN_SP,
    parameter int          TAG_W        = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [63:0]      IN_RS1,
    input  logic [63:0]      IN_RS2,
    input  logic             IN_FMT,
    input  logic [2:0]       IN_FUNCT3,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [63:0]      INPUT_1,
    output logic [63:0]      INPUT_2,
    output logic             SP_DP,
    output logic [2:0]       OPERATION,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             ILLEGAL
);
    import fpu_pkg::*;

    localparam int EW = ENTRY_DATA_W + TAG_W;

    logic [EW-1:0] mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    logic          push, pop, ill;
    logic [63:0]   ub1, ub2;
    op_e           op;
    logic [EW-1:0] head;

    fpu_nan_unbox #(.CANON_NAN_SP(CANON_NAN_SP)) u_unbox_rs1 (.value(IN_RS1), .fmt(IN_FMT), .result(ub1));
    fpu_nan_unbox #(.CANON_NAN_SP(CANON_NAN_SP)) u_unbox_rs2 (.value(IN_RS2), .fmt(IN_FMT), .result(ub2));

    assign op        = decode_funct3(IN_FUNCT3);
    assign ill       = op == OP_NONE;
    assign IN_READY  = count != 2'd2;
    assign OUT_VALID = count != 2'd0;
    // FLUSH suppresses both handshakes so the concurrent input is dropped.
    assign push      = IN_VALID && IN_READY && !FLUSH;
    assign pop       = OUT_VALID && OUT_READY && !FLUSH;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (FLUSH) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {ub1, ub2, IN_FMT, op, ill, IN_TAG};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Stale storage survives a flush, so gate the head by occupancy to keep empty outputs at zero.
    assign head = OUT_VALID ? mem[rd_ptr] : '0;
    assign {INPUT_1, INPUT_2, SP_DP, OPERATION, ILLEGAL, OUT_TAG} = head;
endmodule

// File: tb/tb_fpu_sgnj_operand_stage.sv
// tb_fpu_sgnj_operand_stage: scoreboard bench with directed and random stimulus for the operand stage.
module tb_fpu_sgnj_operand_stage;
    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        dp;
        logic [2:0]  op;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_rs1 = '0;
    logic [63:0] in_rs2 = '0;
    logic        in_fmt = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] input_1, input_2;
    logic        sp_dp;
    logic [2:0]  operation;
    logic [4:0]  out_tag;
    logic        illegal;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    fpu_sgnj_operand_stage dut (
        .CLK(clk), .RST_N(rst_n), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_RS1(in_rs1), .IN_RS2(in_rs2), .IN_FMT(in_fmt), .IN_FUNCT3(in_funct3), .IN_TAG(in_tag),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .INPUT_1(input_1), .INPUT_2(input_2), .SP_DP(sp_dp), .OPERATION(operation),
        .OUT_TAG(out_tag), .ILLEGAL(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] ref_unbox(input logic [63:0] v, input logic dp);
        if (dp) return v;
        if (v / 64'h1_0000_0000 == 64'hFFFF_FFFF) return v % 64'h1_0000_0000;
        return 64'h7FC0_0000;
    endfunction

    function automatic exp_t ref_model(input logic [63:0] r1, input logic [63:0] r2, input logic dp,
                                       input logic [2:0] f3, input logic [4:0] tag);
        exp_t e;
        e.a   = ref_unbox(r1, dp);
        e.b   = ref_unbox(r2, dp);
        e.dp  = dp;
        e.op  = f3 == 0 ? 3'd1 : f3 == 1 ? 3'd2 : f3 == 2 ? 3'd4 : 3'd0;
        e.ill = f3 > 2;
        e.tag = tag;
        return e;
    endfunction

    // One cycle of upstream/downstream stimulus; acceptance follows the model's occupancy.
    task automatic drive(input bit v, input logic [63:0] r1, input logic [63:0] r2, input bit fmt,
                         input logic [2:0] f3, input logic [4:0] tag, input bit ordy, input bit fl,
                         output bit acc);
        @(negedge clk);
        in_valid = v; in_rs1 = r1; in_rs2 = r2; in_fmt = fmt;
        in_funct3 = f3; in_tag = tag; out_ready = ordy; flush = fl;
        acc = v && sb.size() != 2 && !fl;
        @(posedge clk);
        if (acc) sb.push_back(ref_model(r1, r2, fmt, f3, tag));
    endtask

    task automatic idle(input bit ordy);
        bit acc;
        drive(1'b0, '0, '0, 1'b0, 3'd0, 5'd0, ordy, 1'b0, acc);
    endtask

    // Monitor: compares the presented head against the scoreboard and retires on handshake.
    initial begin
        bit do_pop, do_flush;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("out_valid", out_valid, sb.size() != 0);
                check("in_ready", in_ready, sb.size() != 2);
                if (sb.size() != 0) begin
                    check("input_1", input_1, sb[0].a);
                    check("input_2", input_2, sb[0].b);
                    check("sp_dp", sp_dp, sb[0].dp);
                    check("operation", operation, sb[0].op);
                    check("illegal", illegal, sb[0].ill);
                    check("out_tag", out_tag, sb[0].tag);
                end else begin
                    check("empty_data", {input_1 | input_2}, 64'd0);
                    check("empty_ctl", {sp_dp, operation, illegal, out_tag}, 64'd0);
                end
                do_flush = flush;
                do_pop   = out_ready && sb.size() != 0 && !flush;
                @(posedge clk);
                if (do_flush) sb.delete();
                else if (do_pop) void'(sb.pop_front());
            end
        end
    end

    initial begin
        bit acc;
        int tries;
        #3;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_data", input_1 | input_2, 64'd0);
        check("reset_ctl", {sp_dp, operation, illegal, out_tag}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(1'b1);

        // Properly boxed SP, FSGNJ.
        drive(1'b1, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_BF80_0000, 1'b0, 3'b000, 5'd4, 1'b1, 1'b0, acc);
        // Improperly boxed rs2, FSGNJX.
        drive(1'b1, 64'hFFFF_FFFF_3F80_0000, 64'h0000_0001_BF80_0000, 1'b0, 3'b010, 5'd5, 1'b1, 1'b0, acc);
        // DP pass-through FSGNJN, then illegal funct3.
        drive(1'b1, 64'h8000_1234_5678_9ABC, 64'h7FF0_0000_0000_0001, 1'b1, 3'b001, 5'd6, 1'b1, 1'b0, acc);
        drive(1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 3'b011, 5'd7, 1'b1, 1'b0, acc);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: tag 3 must be held upstream until space opens.
        drive(1'b1, 64'd1, 64'd1, 1'b1, 3'd0, 5'd1, 1'b0, 1'b0, acc);
        drive(1'b1, 64'd2, 64'd2, 1'b1, 3'd1, 5'd2, 1'b0, 1'b0, acc);
        drive(1'b1, 64'd3, 64'd3, 1'b1, 3'd2, 5'd3, 1'b0, 1'b0, acc);
        drive(1'b1, 64'd3, 64'd3, 1'b1, 3'd2, 5'd3, 1'b0, 1'b0, acc);
        tries = 0;
        do begin
            drive(1'b1, 64'd3, 64'd3, 1'b1, 3'd2, 5'd3, 1'b1, 1'b0, acc);
            tries++;
        end while (!acc && tries < 8);
        check("bp_tag3_accepted", acc, 1'b1);
        repeat (4) idle(1'b1);

        // Flush with a full queue and a concurrent valid input.
        drive(1'b1, 64'd8, 64'd8, 1'b0, 3'd0, 5'd8, 1'b0, 1'b0, acc);
        drive(1'b1, 64'd9, 64'd9, 1'b0, 3'd0, 5'd9, 1'b0, 1'b0, acc);
        drive(1'b1, 64'd10, 64'd10, 1'b0, 3'd0, 5'd10, 1'b1, 1'b1, acc);
        idle(1'b1);
        idle(1'b1);

        // Async reset mid-stream with one entry queued.
        drive(1'b1, 64'hFFFF_FFFF_0000_0011, 64'd0, 1'b0, 3'd1, 5'd11, 1'b0, 1'b0, acc);
        @(negedge clk);
        mon_en = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_in_ready", in_ready, 1'b1);
        check("async_rst_data", input_1 | input_2, 64'd0);
        check("async_rst_ctl", {sp_dp, operation, illegal, out_tag}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        drive(1'b1, 64'hFFFF_FFFF_4000_0000, 64'hFFFF_FFFF_C000_0000, 1'b0, 3'd2, 5'd12, 1'b1, 1'b0, acc);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [63:0] r1, r2;
            r1 = {($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'hFFFF_FFFF, 32'($urandom)};
            r2 = {($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'hFFFF_FFFF, 32'($urandom)};
            drive($urandom_range(0, 3) != 0, r1, r2, 1'($urandom),
                  ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)),
                  5'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, acc);
        end
        repeat (3) idle(1'b1);
        check("drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
